// File: rtl/tl_conflict_monitor_pkg.sv
// tl_conflict_monitor_pkg
//   Shared definitions for the traffic-light conflict monitor:
//   lamp/light word encodings, fault cause codes, monitor FSM states
//   and small word-classification helpers.
//   Light word layout: {Left, Green, Yellow, Red}.
package tl_conflict_monitor_pkg;

  localparam logic [3:0] LEFT_GREEN     = 4'b1000;
  localparam logic [3:0] STRAIGHT_GREEN = 4'b0100;
  localparam logic [3:0] YELLOW         = 4'b0010;
  localparam logic [3:0] RED            = 4'b0001;
  localparam logic [3:0] LAMP_OFF       = 4'b0000;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_CONFLICT  = 3'd1,
    FC_BAD_ENC   = 3'd2,
    FC_YEL_SKIP  = 3'd3,
    FC_YEL_SHORT = 3'd4,
    FC_STALL     = 3'd5
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_t;

  // A legal light word lights exactly one lamp.
  function automatic logic is_one_hot(input logic [3:0] word);
    return $onehot(word);
  endfunction

  // Any lamp other than red grants (or is about to grant) right of way.
  function automatic logic has_right_of_way(input logic [3:0] word);
    return word[3:1] != 3'b000;
  endfunction

endpackage

// File: rtl/tl_conflict_monitor_if.sv
// tl_conflict_monitor_if
//   Bundle between the intersection controller, the safety monitor and
//   the lamp drivers.
//   master : controller side  - drives light words and fault_clear,
//                               observes lamps and fault status
//   slave  : monitor side     - consumes light words and fault_clear,
//                               drives lamps, fault, fault_code, fault_snap
interface tl_conflict_monitor_if;
  logic [3:0]  north_tl;
  logic [3:0]  south_tl;
  logic [3:0]  east_tl;
  logic [3:0]  west_tl;
  logic        fault_clear;
  logic [3:0]  north_lamp;
  logic [3:0]  south_lamp;
  logic [3:0]  east_lamp;
  logic [3:0]  west_lamp;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] fault_snap;

  modport master (
    output north_tl, south_tl, east_tl, west_tl, fault_clear,
    input  north_lamp, south_lamp, east_lamp, west_lamp,
    input  fault, fault_code, fault_snap
  );

  modport slave (
    input  north_tl, south_tl, east_tl, west_tl, fault_clear,
    output north_lamp, south_lamp, east_lamp, west_lamp,
    output fault, fault_code, fault_snap
  );
endinterface

// File: rtl/tl_conflict_monitor_dir_checker.sv
// tl_conflict_monitor_dir_checker
//   Per-direction sequence checks on the registered light word.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     in_q         current registered light word
//     prev_q       light word of the previous cycle
//     bad_enc      in_q is not one-hot
//     skipped      a green went straight to red without yellow
//     short_yel    yellow left before it was seen MIN_YELLOW cycles
module tl_conflict_monitor_dir_checker
  import tl_conflict_monitor_pkg::*;
#(
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = $clog2(MIN_YELLOW + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_q,
  input  logic [3:0] prev_q,
  output logic       bad_enc,
  output logic       skipped,
  output logic       short_yel
);

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_YEL_CNT = CNT_W'(MIN_YELLOW);

  logic [CNT_W-1:0] yel_cnt;

  // Consecutive cycles the word has been yellow; saturates, so an
  // arbitrarily long yellow never wraps back below the minimum.
  always_ff @(posedge clk) begin
    if (reset) begin
      yel_cnt <= {CNT_W{1'b0}};
    end else if (in_q == YELLOW) begin
      if (yel_cnt != CNT_MAX) begin
        yel_cnt <= yel_cnt + CNT_ONE;
      end else begin
        yel_cnt <= yel_cnt;
      end
    end else begin
      yel_cnt <= {CNT_W{1'b0}};
    end
  end

  // Violation flags for this direction.
  always_comb begin
    bad_enc   = !is_one_hot(in_q);
    skipped   = ((prev_q == LEFT_GREEN) || (prev_q == STRAIGHT_GREEN)) && (in_q == RED);
    short_yel = (prev_q == YELLOW) && (in_q != YELLOW) && (yel_cnt < MIN_YEL_CNT);
  end

endmodule

// File: rtl/tl_conflict_monitor.sv
// tl_conflict_monitor
//   Safety monitor between the intersection FSM and the lamp drivers.
//   Healthy: forwards the four light words to the lamps (2-cycle latency).
//   On a violation: latches the cause, drives all-way flashing red until
//   fault_clear, then re-enters a steady all-red startup period.
//   Ports:
//     clk     clock
//     reset   synchronous, active-high
//     bus     tl_conflict_monitor_if.slave: light words in, fault_clear in,
//             lamps / fault / fault_code / fault_snap out (all registered)
//   Build option: define TL_FAULT_SNAPSHOT_EN to capture the offending
//   {n,s,e,w} words into fault_snap; otherwise fault_snap is constant 0.
module tl_conflict_monitor
  import tl_conflict_monitor_pkg::*;
#(
  parameter int MIN_YELLOW  = 2,
  parameter int WDOG_CYC    = 64,
  parameter int STARTUP_CYC = 8,
  parameter int FLASH_HALF  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tl_conflict_monitor_if.slave bus
);

  localparam int SW = $clog2(WDOG_CYC + 1);
  localparam int TW = $clog2(STARTUP_CYC + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  localparam logic [SW-1:0] STALL_MAX  = {SW{1'b1}};
  localparam logic [SW-1:0] STALL_ONE  = SW'(1);
  localparam logic [SW-1:0] STALL_LAST = SW'(WDOG_CYC - 1);
  localparam logic [TW-1:0] START_ONE  = TW'(1);
  localparam logic [TW-1:0] START_LAST = TW'(STARTUP_CYC - 1);
  localparam logic [FW-1:0] FLASH_ONE  = FW'(1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  localparam logic [15:0] ALL_RED = {RED, RED, RED, RED};
  localparam logic [15:0] ALL_OFF = {LAMP_OFF, LAMP_OFF, LAMP_OFF, LAMP_OFF};

  logic [15:0]   in_q;
  logic [15:0]   prev_q;
  logic [3:0]    bad_dir;
  logic [3:0]    skip_dir;
  logic [3:0]    short_dir;
  logic          conflict;
  logic          stall_hit;
  logic [SW-1:0] stall_cnt;
  fault_code_t   violation;
  mon_state_t    state;
  logic [TW-1:0] start_cnt;
  logic [FW-1:0] flash_cnt;
  logic          flash_on;
  logic [15:0]   lamps;
  logic          fault;
  fault_code_t   code;

  // Input pipeline: {n,s,e,w} words and their one-cycle history.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q   <= 16'h0000;
      prev_q <= 16'h0000;
    end else begin
      in_q   <= {bus.north_tl, bus.south_tl, bus.east_tl, bus.west_tl};
      prev_q <= in_q;
    end
  end

  // Index 0..3 = north, south, east, west.
  for (genvar d = 0; d < 4; d++) begin : g_dir
    tl_conflict_monitor_dir_checker #(
      .MIN_YELLOW (MIN_YELLOW)
    ) u_dir (
      .clk       (clk),
      .reset     (reset),
      .in_q      (in_q[15-4*d -: 4]),
      .prev_q    (prev_q[15-4*d -: 4]),
      .bad_enc   (bad_dir[d]),
      .skipped   (skip_dir[d]),
      .short_yel (short_dir[d])
    );
  end

  // Stall watchdog: cycles with unchanged words; restarted every startup.
  always_ff @(posedge clk) begin
    if (reset || (state == ST_STARTUP)) begin
      stall_cnt <= {SW{1'b0}};
    end else if (in_q != prev_q) begin
      stall_cnt <= {SW{1'b0}};
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + STALL_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  // Conflict and stall detection plus priority encoding of the cause.
  always_comb begin
    conflict  = (has_right_of_way(in_q[15:12]) || has_right_of_way(in_q[11:8])) &&
                (has_right_of_way(in_q[7:4])   || has_right_of_way(in_q[3:0]));
    // This cycle is the WDOG_CYC-th consecutive unchanged one.
    stall_hit = (in_q == prev_q) && (stall_cnt >= STALL_LAST);
    if (conflict) begin
      violation = FC_CONFLICT;
    end else if (|bad_dir) begin
      violation = FC_BAD_ENC;
    end else if (|skip_dir) begin
      violation = FC_YEL_SKIP;
    end else if (|short_dir) begin
      violation = FC_YEL_SHORT;
    end else if (stall_hit) begin
      violation = FC_STALL;
    end else begin
      violation = FC_NONE;
    end
  end

  // Monitor FSM with flash timer and registered lamp/fault outputs.
  // On fault entry the lamps take all-red in the same edge, so the
  // violating word is never forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STARTUP;
      start_cnt <= {TW{1'b0}};
      flash_cnt <= {FW{1'b0}};
      flash_on  <= 1'b1;
      lamps     <= ALL_RED;
      fault     <= 1'b0;
      code      <= FC_NONE;
    end else begin
      case (state)
        ST_STARTUP: begin
          lamps     <= ALL_RED;
          fault     <= 1'b0;
          code      <= FC_NONE;
          flash_cnt <= {FW{1'b0}};
          flash_on  <= 1'b1;
          if (start_cnt == START_LAST) begin
            state     <= ST_PASS;
            start_cnt <= {TW{1'b0}};
          end else begin
            state     <= ST_STARTUP;
            start_cnt <= start_cnt + START_ONE;
          end
        end
        ST_PASS: begin
          start_cnt <= {TW{1'b0}};
          flash_cnt <= {FW{1'b0}};
          flash_on  <= 1'b1;
          if (violation != FC_NONE) begin
            state <= ST_FAULT;
            fault <= 1'b1;
            code  <= violation;
            lamps <= ALL_RED;
          end else begin
            state <= ST_PASS;
            fault <= 1'b0;
            code  <= FC_NONE;
            lamps <= in_q;
          end
        end
        ST_FAULT: begin
          start_cnt <= {TW{1'b0}};
          if (bus.fault_clear) begin
            state     <= ST_STARTUP;
            fault     <= 1'b0;
            code      <= FC_NONE;
            lamps     <= ALL_RED;
            flash_cnt <= {FW{1'b0}};
            flash_on  <= 1'b1;
          end else if (flash_cnt == FLASH_LAST) begin
            state     <= ST_FAULT;
            fault     <= 1'b1;
            code      <= code;
            flash_cnt <= {FW{1'b0}};
            flash_on  <= !flash_on;
            lamps     <= flash_on ? ALL_OFF : ALL_RED;
          end else begin
            state     <= ST_FAULT;
            fault     <= 1'b1;
            code      <= code;
            flash_cnt <= flash_cnt + FLASH_ONE;
            flash_on  <= flash_on;
            lamps     <= flash_on ? ALL_RED : ALL_OFF;
          end
        end
        default: begin
          state     <= ST_STARTUP;
          start_cnt <= {TW{1'b0}};
          flash_cnt <= {FW{1'b0}};
          flash_on  <= 1'b1;
          lamps     <= ALL_RED;
          fault     <= 1'b0;
          code      <= FC_NONE;
        end
      endcase
    end
  end

`ifdef TL_FAULT_SNAPSHOT_EN
  logic [15:0] snap;

  // Capture the offending words on fault entry; drop them on clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap <= 16'h0000;
    end else if ((state == ST_PASS) && (violation != FC_NONE)) begin
      snap <= in_q;
    end else if ((state == ST_FAULT) && bus.fault_clear) begin
      snap <= 16'h0000;
    end else begin
      snap <= snap;
    end
  end

  assign bus.fault_snap = snap;
`else
  assign bus.fault_snap = 16'h0000;
`endif

  assign bus.north_lamp = lamps[15:12];
  assign bus.south_lamp = lamps[11:8];
  assign bus.east_lamp  = lamps[7:4];
  assign bus.west_lamp  = lamps[3:0];
  assign bus.fault      = fault;
  assign bus.fault_code = code;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// tb_tl_conflict_monitor
//   Self-checking bench: directed scenarios plus randomized light words,
//   compared each cycle against a history-based reference model.
module tb_tl_conflict_monitor;

  localparam int MIN_YELLOW  = 2;
  localparam int WDOG_CYC    = 64;
  localparam int STARTUP_CYC = 8;
  localparam int FLASH_HALF  = 4;
  localparam int M_START = 0;
  localparam int M_PASS  = 1;
  localparam int M_FAULT = 2;

  logic clk = 1'b0;
  logic reset;

  tl_conflict_monitor_if bus ();

  tl_conflict_monitor #(
    .MIN_YELLOW  (MIN_YELLOW),
    .WDOG_CYC    (WDOG_CYC),
    .STARTUP_CYC (STARTUP_CYC),
    .FLASH_HALF  (FLASH_HALF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int lamp_conflicts = 0;

  // Reference model state: in_q history since reset, newest last.
  logic [15:0] hist[$];
  int          mode = M_START;
  int          startup_edges = 0;
  int          fault_edges = 0;
  int          pass_cycles = 0;
  logic [15:0] exp_lamps = 16'h1111;
  logic [15:0] exp_snap = 16'h0000;
  logic        exp_fault = 1'b0;
  logic [2:0]  exp_code = 3'd0;

  logic [15:0] legal_tbl [8] = '{16'h8811, 16'h4411, 16'h2211, 16'h1111,
                                 16'h1188, 16'h1144, 16'h1122, 16'h1111};
  logic [3:0]  lights [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] word_of(input logic [15:0] v, input int d);
    return v[15-4*d -: 4];
  endfunction

  // Rule evaluation on the current / previous registered words.
  function automatic int model_violation();
    int sz;
    int run;
    logic [15:0] cur;
    logic [15:0] prv;
    sz  = hist.size();
    cur = hist[sz-1];
    prv = hist[sz-2];
    if ((((word_of(cur, 0) | word_of(cur, 1)) & 4'b1110) != 4'b0000) &&
        (((word_of(cur, 2) | word_of(cur, 3)) & 4'b1110) != 4'b0000)) return 1;
    for (int d = 0; d < 4; d++)
      if ($countones(word_of(cur, d)) != 1) return 2;
    for (int d = 0; d < 4; d++)
      if (((word_of(prv, d) == 4'b1000) || (word_of(prv, d) == 4'b0100)) && (word_of(cur, d) == 4'b0001)) return 3;
    for (int d = 0; d < 4; d++) begin
      if ((word_of(prv, d) == 4'b0010) && (word_of(cur, d) != 4'b0010)) begin
        run = 0;
        for (int i = sz - 2; i >= 0; i--) begin
          if (word_of(hist[i], d) == 4'b0010) run++;
          else break;
        end
        if (run < MIN_YELLOW) return 4;
      end
    end
    run = 0;
    for (int k = 0; (k < pass_cycles) && (k < WDOG_CYC) && (sz - 2 - k >= 0); k++) begin
      if (hist[sz-1-k] == hist[sz-2-k]) run++;
      else break;
    end
    if (run >= WDOG_CYC) return 5;
    return 0;
  endfunction

  // Advance the model by one clock edge with the inputs sampled there.
  task automatic model_edge(input logic [15:0] x, input bit rst, input bit clr);
    int v;
    int old_mode;
    if (rst) begin
      mode = M_START; startup_edges = 0; fault_edges = 0; pass_cycles = 0;
      exp_lamps = 16'h1111; exp_fault = 1'b0; exp_code = 3'd0; exp_snap = 16'h0000;
      hist.delete();
      hist.push_back(16'h0000);
      hist.push_back(16'h0000);
      return;
    end
    old_mode = mode;
    v = (mode == M_PASS) ? model_violation() : 0;
    if (mode == M_START) begin
      exp_lamps = 16'h1111;
      startup_edges++;
      if (startup_edges == STARTUP_CYC) mode = M_PASS;
    end else if (mode == M_PASS) begin
      if (v != 0) begin
        mode = M_FAULT; fault_edges = 0;
        exp_fault = 1'b1; exp_code = 3'(v); exp_lamps = 16'h1111;
`ifdef TL_FAULT_SNAPSHOT_EN
        exp_snap = hist[hist.size()-1];
`endif
      end else begin
        exp_lamps = hist[hist.size()-1];
      end
    end else begin
      if (clr) begin
        mode = M_START; startup_edges = 0;
        exp_fault = 1'b0; exp_code = 3'd0; exp_snap = 16'h0000; exp_lamps = 16'h1111;
      end else begin
        fault_edges++;
        exp_lamps = (((fault_edges / FLASH_HALF) % 2) == 0) ? 16'h1111 : 16'h0000;
      end
    end
    pass_cycles = (mode == M_PASS) ? ((old_mode == M_PASS) ? pass_cycles + 1 : 1) : 0;
    hist.push_back(x);
    if (hist.size() > 140) void'(hist.pop_front());
  endtask

  function automatic logic [15:0] dut_lamps();
    return {bus.north_lamp, bus.south_lamp, bus.east_lamp, bus.west_lamp};
  endfunction

  // One clock: drive, let the edge happen, update model, compare.
  task automatic step(input logic [15:0] w, input bit rst, input bit clr);
    logic [15:0] lw;
    reset           = rst;
    bus.north_tl    = w[15:12];
    bus.south_tl    = w[11:8];
    bus.east_tl     = w[7:4];
    bus.west_tl     = w[3:0];
    bus.fault_clear = clr;
    @(posedge clk);
    model_edge(w, rst, clr);
    #1;
    lw = dut_lamps();
    check_eq("lamps", 32'(lw), 32'(exp_lamps));
    check_eq("fault", 32'(bus.fault), 32'(exp_fault));
    check_eq("fault_code", 32'(bus.fault_code), 32'(exp_code));
    check_eq("fault_snap", 32'(bus.fault_snap), 32'(exp_snap));
    if ((((lw[15:12] | lw[11:8]) & 4'b1110) != 4'b0000) &&
        (((lw[7:4] | lw[3:0]) & 4'b1110) != 4'b0000)) lamp_conflicts++;
  endtask

  function automatic int phase_len(input int ph);
    case (ph % 4)
      0:       return int'($urandom_range(6, 5));
      1:       return int'($urandom_range(8, 5));
      2:       return int'($urandom_range(4, 3));
      default: return int'($urandom_range(2, 1));
    endcase
  endfunction

  // Legal 8-phase cycle with randomized phase lengths.
  task automatic run_legal(input int n, output int faults);
    int ph;
    int left;
    ph = 0;
    left = phase_len(ph);
    faults = 0;
    for (int c = 0; c < n; c++) begin
      step(legal_tbl[ph], 1'b0, 1'b0);
      if (bus.fault) faults++;
      left--;
      if (left == 0) begin
        ph = (ph + 1) % 8;
        left = phase_len(ph);
      end
    end
  endtask

  task automatic clear_and_settle();
    step(16'h1111, 1'b0, 1'b1);
    repeat (12) step(16'h1111, 1'b0, 1'b0);
  endtask

  initial begin
    int faults;
    int r;
    int idx;
    logic [3:0] a;
    logic [15:0] w;

    // Reset values.
    repeat (3) step(16'h1111, 1'b1, 1'b0);
    check_eq("rst_lamps", 32'(dut_lamps()), 32'h1111);
    check_eq("rst_fault", 32'(bus.fault), 32'd0);
    check_eq("rst_code", 32'(bus.fault_code), 32'd0);
    check_eq("rst_snap", 32'(bus.fault_snap), 32'd0);

    // Legal sequence: never faults, lamps follow inputs two cycles late.
    run_legal(500, faults);
    check_eq("legal_no_fault", 32'(faults), 32'd0);

    // Conflict: north straight green with east left green.
    step(16'h4181, 1'b0, 1'b0);
    step(16'h1111, 1'b0, 1'b0);
    check_eq("conflict_fault", 32'(bus.fault), 32'd1);
    check_eq("conflict_code", 32'(bus.fault_code), 32'd1);
    repeat (20) step(16'h1111, 1'b0, 1'b0);

    // Green straight to red.
    clear_and_settle();
    repeat (3) step(16'h4111, 1'b0, 1'b0);
    repeat (2) step(16'h1111, 1'b0, 1'b0);
    check_eq("skip_code", 32'(bus.fault_code), 32'd3);

    // Yellow held only one cycle.
    clear_and_settle();
    repeat (3) step(16'h4111, 1'b0, 1'b0);
    step(16'h2111, 1'b0, 1'b0);
    repeat (2) step(16'h4111, 1'b0, 1'b0);
    check_eq("short_code", 32'(bus.fault_code), 32'd4);

    // Frozen inputs trip the watchdog.
    step(16'h1111, 1'b0, 1'b1);
    for (int i = 0; (i < 100) && !bus.fault; i++) step(16'h1111, 1'b0, 1'b0);
    check_eq("stall_fault", 32'(bus.fault), 32'd1);
    check_eq("stall_code", 32'(bus.fault_code), 32'd5);

    // Recovery: startup then pass-through.
    clear_and_settle();
    run_legal(60, faults);
    check_eq("recover_no_fault", 32'(faults), 32'd0);

    // Conflict and bad encoding together: conflict wins.
    step(16'h6144, 1'b0, 1'b0);
    step(16'h1111, 1'b0, 1'b0);
    check_eq("dual_code", 32'(bus.fault_code), 32'd1);
`ifdef TL_FAULT_SNAPSHOT_EN
    check_eq("dual_snap", 32'(bus.fault_snap), 32'h6144);
`else
    check_eq("dual_snap", 32'(bus.fault_snap), 32'h0000);
`endif

    // Reset during the dark half of the flash.
    for (int i = 0; (i < 20) && (dut_lamps() != 16'h0000); i++) step(16'h1111, 1'b0, 1'b0);
    check_eq("flash_off_seen", 32'(dut_lamps()), 32'h0000);
    step(16'h1111, 1'b1, 1'b0);
    check_eq("midrst_lamps", 32'(dut_lamps()), 32'h1111);
    check_eq("midrst_fault", 32'(bus.fault), 32'd0);
    check_eq("midrst_code", 32'(bus.fault_code), 32'd0);
    repeat (8) step(16'h1188, 1'b0, 1'b0);

    // Randomized words, clears and occasional resets.
    w = 16'h1111;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3, 0) == 0) begin
        idx = int'($urandom_range(3, 0));
        a = lights[idx];
        if ($urandom_range(19, 0) == 0) w = 16'($urandom);
        else if ($urandom_range(1, 0) == 0) w = {a, a, 4'b0001, 4'b0001};
        else w = {4'b0001, 4'b0001, a, a};
      end
      r = int'($urandom_range(99, 0));
      step(w, r == 0, (r >= 1) && (r < 12));
    end

    check_eq("lamp_conflict_never", 32'(lamp_conflicts), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
